// File: rtl/fifo_param_pkg.sv
// Shared constants for the switch datapath FIFO: packet width, flag levels, default depth.
package fifo_param_pkg;

    localparam int PKTW       = 9;
    localparam int FIFO_DEPTH = 16;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    function automatic logic flag(input logic cond);
        return cond ? ASSERT : NEGATE;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: low bits address storage, MSB is the wrap bit; flush reloads from another pointer.
module fifo_ptr #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inc,
    input  logic [AW:0] load,
    output logic [AW:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (flush)
            ptr <= load;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through packet FIFO with occupancy, almost-full and sticky errors.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH     = PKTW + 1,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     we,
    input  logic [WIDTH-1:0]         pkti,
    input  logic                     re,
    output logic [WIDTH-1:0]         pkto,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_T = AF_THRESH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      head, tail;
    logic             wr_ok, re_ok;

    assign empty       = flag(head == tail);
    assign full        = flag((head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]));
    assign count       = head - tail;
    assign almost_full = flag(count >= AF_T);
    assign pkto        = empty ? '0 : mem[tail[AW-1:0]];

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign re_ok = re & ~empty;
    assign wr_ok = we & (~full | re_ok);

    // Flush snaps head back onto tail; tail reloads itself so it simply holds.
    fifo_ptr #(.AW(AW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (wr_ok),
        .load  (tail),
        .ptr   (head)
    );

    fifo_ptr #(.AW(AW)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (re_ok),
        .load  (tail),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (wr_ok && !flush)
            mem[head[AW-1:0]] <= pkti;
    end

    // Set beats clear; a flush cycle never raises an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= NEGATE;
            udf <= NEGATE;
        end else if (flush) begin
            ovf <= ovf & ~err_clr;
            udf <= udf & ~err_clr;
        end else begin
            ovf <= (ovf & ~err_clr) | (we & ~wr_ok);
            udf <= (udf & ~err_clr) | (re & empty);
        end
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised packet FIFO for the switch datapath; the next-generation replacement for the fixed 16-entry, 10-bit router buffer.
- Adds full usable depth (no dummy slot), occupancy count, almost-full threshold for upstream back-pressure, synchronous flush, and sticky overflow/underflow error flags.
- Read data is first-word-fall-through.

Parameters:
- WIDTH, 10, packet width in bits; default matches `PKTW+1.
- DEPTH, 16, number of storage entries. Must be a power of two and at least 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH. Legal range is 1..DEPTH.

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; error flags are kept.
- we  in  1  write request.
- pkti  in  WIDTH  write data.
- re  in  1  read request (pop).
- pkto  out  WIDTH  head-of-queue data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky: a write was dropped.
- udf  out  1  sticky: a read was ignored.
- err_clr  in  1  clears ovf and udf.

Behaviour:
- Storage and pointers:
  - Storage is mem[0..DEPTH-1].
  - head (write) and tail (read) pointers are $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
  - Addresses use the low $clog2(DEPTH) bits. Pointers wrap naturally modulo 2*DEPTH.
- Status decode (combinational from registered state):
  - empty = (head == tail).
  - full = (low bits equal) and (wrap bits differ).
  - count = head - tail, modulo 2*DEPTH.
  - Flags use `ASSERT/`NEGATE levels.
- Output:
  - pkto = mem[tail low bits] when not empty, otherwise all zeros.
  - Zero latency: a word written at edge N is visible on pkto after edge N when the FIFO was empty.
- Effective operations:
  - wr_ok = we & (~full | re_ok).
  - re_ok = re & ~empty.
  - On wr_ok: mem[head] <= pkti and head <= head+1.
  - On re_ok: tail <= tail+1.
- Simultaneous events:
  - re and we together when full: both succeed and count stays at DEPTH.
  - re and we together when empty: only the write takes effect; udf sets; count becomes 1.
- Sticky errors:
  - we & ~wr_ok sets ovf; the data is discarded and the pointers are unchanged.
  - re & empty sets udf.
  - err_clr clears both flags. If err_clr and a new error occur in the same cycle, the set wins.
- Priority: rst > flush > normal operation.
  - rst: head = tail = 0, ovf = udf = 0. Memory contents are don't-care, because pkto is forced to 0 while empty.
  - flush: head <= tail. we/re are ignored that cycle and no error flags are set.
- Reset values, held from the cycle after rst is asserted:
  - empty=1, full=0, almost_full=0 (almost_full=1 only if AF_THRESH would be 0, which is illegal).
  - count=0, pkto=0, ovf=0, udf=0.
- Reset mid-operation: all queued data is lost. The first write after rst deasserts behaves as a write to an empty FIFO.
- Memory: no reset on the array, so it may map to distributed RAM.

Decomposition:
- Shared constants go in sw.vh: `PKTW, `ASSERT/`NEGATE, and a default `FIFO_DEPTH.
- Pointer arithmetic and status decode stay local.
- Natural sub-module: fifo_ptr (pointer register with increment, wrap bit and flush load), instantiated twice.
- Storage array and output mux stay in fifo_param.

Test Plan (WIDTH=10, DEPTH=4, AF_THRESH=3):
- Reset, then write 0x101, 0x102, 0x103, 0x104 on consecutive cycles.
  - count goes 1,2,3,4; almost_full rises after the 3rd write; full after the 4th; pkto=0x101 from the first edge.
- Full, then a 5th write of 0x3FF with re=0.
  - Write is dropped; ovf=1; count=4. Draining then returns 0x101..0x104 in order; empty=1; pkto=0.
- Full, then re=we=1 with pkti=0x2AA.
  - count stays 4; pkto becomes 0x102. After 4 pops the last word read is 0x2AA.
- Empty, then re=1 with we=1 and pkti=0x055.
  - udf=1; count=1; pkto=0x055.
- Eight write/read pairs to force pointer wrap.
  - Data is preserved in order; full and empty never assert spuriously.
- Three words queued, then flush=1 with we=1.
  - Next cycle: empty=1, count=0, no write, ovf unchanged.
- Then rst=1 with ovf=1 set.
  - ovf=0 and empty=1 on the next cycle.
